// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_arbiter
// Brief    : Round-robin arbiter sharing one W-bit adder among NREQ
//            requesters. Captures the winner's operands on grant, adds them
//            in the next cycle and holds the registered result with a
//            valid/ready handshake until the consumer accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         in1,
  input  logic [NREQ*W-1:0]         in2,
  output logic [NREQ-1:0]           gnt,
  output logic [W-1:0]              out,
  output logic                      cout,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q,   ptr_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [IW-1:0]   id_q,    id_d;
  logic [W:0]      sum_q,   sum_d;
  logic            valid_q, valid_d;

  logic            found;
  logic [IW-1:0]   win;
  int              idx;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  // Next-state and grant logic; the grant is suppressed while reset is high.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    gnt     = '0;
    case (state_q)
      S_IDLE: begin
        if (found && !rst) begin
          gnt[win] = 1'b1;
          a_d      = in1[win*W +: W];
          b_d      = in2[win*W +: W];
          id_d     = win;
          ptr_d    = (int'(win) == NREQ-1) ? '0 : win + IW'(1);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // Extend by one bit so the carry lands in the top of the sum.
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        valid_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign out       = sum_q[W-1:0];
  assign cout      = sum_q[W];
  assign out_id    = id_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_arbiter
// Brief    : Directed self-checking bench for add_arbiter (NREQ=4, W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [3:0]  gnt;
  logic [3:0]  out;
  logic        cout;
  logic [1:0]  out_id;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  add_arbiter #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .gnt       (gnt),
    .out       (out),
    .cout      (cout),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int slot, input logic [3:0] a, input logic [3:0] b);
    in1[slot*4 +: 4] = a;
    in2[slot*4 +: 4] = b;
  endtask

  // Called just after a falling edge with the DUT in IDLE; returns the same way.
  task automatic do_op(input string tag, input logic [3:0] r, input logic [3:0] r_hold,
                       input logic [31:0] e_gnt, input logic [31:0] e_out,
                       input logic [31:0] e_cout, input logic [31:0] e_id);
    req = r;
    #1;
    chk_eq({tag, "_gnt"}, 32'(gnt), e_gnt);
    chk_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    req = r_hold;
    #1;
    chk_eq({tag, "_exec_gnt"}, 32'(gnt), 32'd0);
    chk_eq({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk_eq({tag, "_exec_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk_eq({tag, "_out"}, 32'(out), e_out);
    chk_eq({tag, "_cout"}, 32'(cout), e_cout);
    chk_eq({tag, "_id"}, 32'(out_id), e_id);
    chk_eq({tag, "_resp_gnt"}, 32'(gnt), 32'd0);
    @(negedge clk);
    #1;
    chk_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;

    // Reset state, with requests present to show reset priority.
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk_eq("rst_gnt",   32'(gnt),       32'd0);
    chk_eq("rst_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_busy",  32'(busy),      32'd0);
    chk_eq("rst_out",   32'(out),       32'd0);
    chk_eq("rst_cout",  32'(cout),      32'd0);
    chk_eq("rst_id",    32'(out_id),    32'd0);

    // Single requester 0: 5+7 = 12.
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    set_ops(0, 4'd5, 4'd7);
    do_op("r0_5p7", 4'b0001, 4'b0000, 32'h1, 32'hC, 32'd0, 32'd0);

    // Requester 2: 8+9 = 17 -> out 1, carry 1.
    set_ops(2, 4'd8, 4'd9);
    do_op("r2_8p9", 4'b0100, 4'b0000, 32'h4, 32'h1, 32'd1, 32'd2);

    // Round robin from a fresh pointer with all requests held.
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 4'd1, 4'd3);
    set_ops(1, 4'd2, 4'd5);
    set_ops(2, 4'd3, 4'd7);
    set_ops(3, 4'd4, 4'hE);
    do_op("rr0", 4'b1111, 4'b1111, 32'h1, 32'h4, 32'd0, 32'd0);
    do_op("rr1", 4'b1111, 4'b1111, 32'h2, 32'h7, 32'd0, 32'd1);
    do_op("rr2", 4'b1111, 4'b1111, 32'h4, 32'hA, 32'd0, 32'd2);
    do_op("rr3", 4'b1111, 4'b1111, 32'h8, 32'h2, 32'd1, 32'd3);
    do_op("rr4", 4'b1111, 4'b1111, 32'h1, 32'h4, 32'd0, 32'd0);

    // Backpressure: pointer is 1, only requester 0 asks; A+9 = 0x13.
    set_ops(0, 4'hA, 4'h9);
    out_ready = 1'b0;
    req = 4'b0001;
    #1;
    chk_eq("bp_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      chk_eq("bp_hold_out",   32'(out),       32'h3);
      chk_eq("bp_hold_cout",  32'(cout),      32'd1);
      chk_eq("bp_hold_id",    32'(out_id),    32'd0);
      chk_eq("bp_hold_gnt",   32'(gnt),       32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk_eq("bp_still_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #1;
    chk_eq("bp_accept_valid", 32'(out_valid), 32'd0);
    chk_eq("bp_next_gnt",     32'(gnt),       32'h2);

    // Reset during EXEC: operation discarded, pointer back to 0.
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("abort_valid", 32'(out_valid), 32'd0);
    chk_eq("abort_busy",  32'(busy),      32'd0);
    chk_eq("abort_out",   32'(out),       32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk_eq("abort_no_valid", 32'(out_valid), 32'd0);

    // Requests 1010 after reset: pointer 0 selects requester 1; 3+4 with
    // operand A disturbed after the grant still yields 7.
    set_ops(1, 4'd3, 4'd4);
    req = 4'b1010;
    #1;
    chk_eq("post_rst_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    req = '0;
    in1[7:4] = 4'hF;
    #1;
    chk_eq("late_op_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk_eq("late_op_valid", 32'(out_valid), 32'd1);
    chk_eq("late_op_out",   32'(out),       32'h7);
    chk_eq("late_op_cout",  32'(cout),      32'd0);
    chk_eq("late_op_id",    32'(out_id),    32'd1);
    @(negedge clk);
    #1;
    chk_eq("late_op_done", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Parameters
REQ-001 SHALL: NREQ, 4, number of requesters sharing the adder (2..8).
REQ-002 SHALL: W, 4, operand and sum width in bits.

Interface
REQ-003 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL: req  in  NREQ  per-requester request; bit i held high until gnt[i] seen.
REQ-006 SHALL: in1  in  NREQ*W  operand A; requester i at bits [i*W +: W].
REQ-007 SHALL: in2  in  NREQ*W  operand B; same packing as in1.
REQ-008 SHALL: gnt  out  NREQ  one-hot grant, one-cycle pulse when operands captured.
REQ-009 SHALL: out  out  W  registered sum, low W bits of A+B.
REQ-010 SHALL: cout  out  1  carry out of A+B (bit W of W+1-bit sum).
REQ-011 SHALL: out_id  out  $clog2(NREQ)  index of requester that owns out.
REQ-012 SHALL: out_valid  out  1  out/cout/out_id valid; held until accepted.
REQ-013 SHALL: out_ready  in  1  consumer accept; transfer when out_valid & out_ready.
REQ-014 SHALL: busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL: FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 SHALL: IDLE, req!=0 -> pick winner, assert gnt[winner] that cycle, latch in1/in2 slices and winner id, go EXEC.
REQ-017 SHALL: IDLE, req==0 -> stay IDLE, gnt=0.
REQ-018 SHALL: winner = first set req bit scanning from pointer ptr upward, wrapping NREQ-1 -> 0.
REQ-019 SHALL: ptr reset 0; on grant ptr <= (winner+1) mod NREQ.
REQ-020 SHALL: EXEC -> compute latched A+B as W+1 bits, register into {cout,out}, set out_valid, go RESP (exactly one cycle).
REQ-021 SHALL: RESP -> hold out, cout, out_id, out_valid stable until out_ready; on accept clear out_valid, go IDLE.
REQ-022 SHALL: latency grant->out_valid = 2 clk edges; minimum issue interval 3 cycles with out_ready held high.
REQ-023 SHALL: no grant issued in EXEC or RESP; req changes there ignored.
REQ-024 SHALL: operand changes after the grant cycle do not affect the in-flight result.
REQ-025 SHALL: out_ready while out_valid=0 has no effect.
REQ-026 SHALL: gnt combinational from state/req/ptr, only in IDLE; never more than one bit set.
REQ-027 SHALL: addition wraps modulo 2^W in out; overflow reported only via cout.

Reset
REQ-028 SHALL: rst=1 at a rising edge -> state IDLE, ptr=0, out=0, cout=0, out_id=0, out_valid=0, busy=0; gnt=0 while rst high.
REQ-029 SHALL: rst mid-EXEC or mid-RESP aborts the operation; result discarded, no out_valid afterwards.
REQ-030 SHALL: rst has priority over all other inputs in the same cycle.

Verification
REQ-031 SHALL: single req[0], in1[0]=5, in2[0]=7, out_ready=1 -> gnt=0001, 2 cycles later out=1100, cout=0, out_id=0, out_valid 1 cycle.
REQ-032 SHALL: req[2], 8+9 -> out=0001, cout=1, out_id=2.
REQ-033 SHALL: req=1111 held, out_ready=1 -> grants 0001,0010,0100,1000,0001 every 3 cycles, out_id 0,1,2,3,0.
REQ-034 SHALL: out_ready=0 for 5 cycles in RESP -> out/cout/out_id stable, out_valid high, gnt=0, then accept -> IDLE, next grant next cycle.
REQ-035 SHALL: rst asserted the cycle after a grant -> out_valid never rises, ptr=0, next req=1010 grants 0010.
REQ-036 SHALL: in1[1] changed to 4'hF the cycle after gnt[1] with original 3+4 -> out=0111.
